cplx_alu_issue: RTL
===================

Name: cplx_alu_issue

Overview:
- Upstream issue/writeback controller for the complex-number ALU.
- Operands are 64-bit complex words: {Re[63:32], Im[31:0]}, both signed 32-bit.
- Holds a small complex register file loaded by the host.
- Accepts 3-address commands (rd = ra opr rb) over a valid/ready handshake and latches the operands.
- Drives the ALU's inA/inB/opr/start, waits for done, then writes the result back to the register file and reports it.

Parameters:
NREGS, 8, number of 64-bit complex registers (power of 2)
AW, 3, register address width, log2(NREGS)
MIN_WAIT, 2, cycles after start assertion before alu_done is honoured (ALU result is doubly registered)
TIMEOUT, 64, max cycles in WAIT before abort; counter width is clog2(TIMEOUT+1)
MAX_OPR, 10, highest legal opcode (5'b01010)

Ports:
clock  in  1  master clock, posedge
reset  in  1  synchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  controller can accept a command
cmd_opr  in  5  ALU opcode
cmd_rd  in  AW  destination register
cmd_ra  in  AW  source register A
cmd_rb  in  AW  source register B
wr_en  in  1  host register write
wr_addr  in  AW  host write address
wr_data  in  64  host write data
rd_addr  in  AW  host read address
rd_data  out  64  combinational read of regfile[rd_addr]
alu_inA  out  64  registered operand A to ALU
alu_inB  out  64  registered operand B to ALU
alu_opr  out  5  registered opcode to ALU
alu_start  out  1  ALU start, held high for the whole operation
alu_outAB  in  64  ALU result
alu_done  in  1  ALU result valid
busy  out  1  high in any state other than IDLE
res_valid  out  1  one-cycle pulse: result written back
res_data  out  64  result of last completed operation, held
res_rd  out  AW  destination of last completed operation, held
err_opr  out  1  one-cycle pulse: illegal opcode rejected
err_timeout  out  1  one-cycle pulse: operation aborted

Behaviour:
- Reset: regfile all 0; alu_inA/alu_inB/res_data = 0; alu_opr = 0; res_rd = 0; alu_start/res_valid/err_* = 0; state = IDLE. Reset mid-operation aborts immediately with no writeback; alu_start is low the next cycle.
- Handshake: cmd_ready = (state==IDLE) && !reset. A command is accepted when cmd_valid && cmd_ready at a posedge.
- States: IDLE, ISSUE, WAIT, WB.
- IDLE, legal command accepted:
  - Latch alu_inA=regfile[cmd_ra], alu_inB=regfile[cmd_rb], alu_opr=cmd_opr, rd.
  - Go to ISSUE.
  - If wr_en targets cmd_ra/cmd_rb in the same cycle, the pre-write (old) value is latched.
- IDLE, illegal opcode accepted (cmd_opr > MAX_OPR): pulse err_opr the next cycle, stay in IDLE, no ALU activity.
- ISSUE: alu_start=1; clear the wait counter; go to WAIT.
- WAIT:
  - alu_start stays 1; the counter increments each cycle.
  - alu_done is ignored while counter < MIN_WAIT.
  - When alu_done=1 and counter >= MIN_WAIT: capture alu_outAB into res_data and res_rd=rd; go to WB.
  - Else when counter == TIMEOUT: pulse err_timeout, drop alu_start, go to IDLE, no writeback.
- WB:
  - regfile[rd] <= res_data; res_valid=1 for this cycle; alu_start=0.
  - Go to IDLE.
  - Total latency from accept to res_valid for a done seen at the first legal cycle is MIN_WAIT+3 cycles.
- alu_inA/alu_inB/alu_opr are stable from ISSUE until the next accept.
- Host writes (wr_en) are accepted in any state and do not disturb latched operands.
- A wr_en in the WB cycle to the same address as rd: writeback wins.
- rd_data is a combinational read of the register file (pre-write value in a write cycle).
- Opcode 5'b00111 is legal; it completes by done or by timeout.

Test Plan:
- Load r1=0x00000003_00000004 and r2=0x00000001_00000002; issue opr=2 (A+B), rd=3, ra=1, rb=2; ALU model asserts done at counter=2 with 0x00000004_00000006 -> res_valid pulses 5 cycles after accept; rd_data(3)=0x00000004_00000006; cmd_ready low throughout.
- Same command with an ALU model that pulses done at counter 0 and 1 only -> done ignored; err_timeout pulses at counter=64; r3 unchanged; cmd_ready high the next cycle.
- Issue opr=5'b01011 -> err_opr pulse; alu_start never rises; busy stays 0.
- During WAIT, host writes r1=0xFFFFFFFF_00000000 -> alu_inA unchanged; r1 updated; the result reflects the old operand.
- In the WB cycle, host writes rd with 0x12345678_9ABCDEF0 -> the register holds the ALU result.
- Assert reset in WAIT -> next cycle alu_start=0, state IDLE, all regs 0, no res_valid.

Source files
------------

// File: rtl/cplx_alu_issue_if.sv
`default_nettype none
// ============================================================================
// Module   : cplx_alu_issue_if
// Brief    : Command, host register-port, ALU and status bundle for the
//            complex ALU issue/writeback controller.
// Revision : 1.0 - initial release
// ============================================================================
interface cplx_alu_issue_if #(
    parameter int AW = 3
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [4:0]    cmd_opr;
    logic [AW-1:0] cmd_rd;
    logic [AW-1:0] cmd_ra;
    logic [AW-1:0] cmd_rb;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [63:0]   wr_data;
    logic [AW-1:0] rd_addr;
    logic [63:0]   rd_data;

    logic [63:0]   alu_inA;
    logic [63:0]   alu_inB;
    logic [4:0]    alu_opr;
    logic          alu_start;
    logic [63:0]   alu_outAB;
    logic          alu_done;

    logic          busy;
    logic          res_valid;
    logic [63:0]   res_data;
    logic [AW-1:0] res_rd;
    logic          err_opr;
    logic          err_timeout;

    modport master (
        output cmd_valid, cmd_opr, cmd_rd, cmd_ra, cmd_rb,
        output wr_en, wr_addr, wr_data, rd_addr,
        output alu_outAB, alu_done,
        input  cmd_ready, rd_data,
        input  alu_inA, alu_inB, alu_opr, alu_start,
        input  busy, res_valid, res_data, res_rd, err_opr, err_timeout
    );

    modport slave (
        input  cmd_valid, cmd_opr, cmd_rd, cmd_ra, cmd_rb,
        input  wr_en, wr_addr, wr_data, rd_addr,
        input  alu_outAB, alu_done,
        output cmd_ready, rd_data,
        output alu_inA, alu_inB, alu_opr, alu_start,
        output busy, res_valid, res_data, res_rd, err_opr, err_timeout
    );
endinterface
`default_nettype wire

// File: rtl/cplx_alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : cplx_alu_issue
// Brief    : Issue/writeback controller for the complex ALU: register file,
//            3-address command intake, ALU sequencing and result writeback.
// Revision : 1.0 - initial release
// ============================================================================
module cplx_alu_issue #(
    parameter int NREGS    = 8,
    parameter int AW       = 3,
    parameter int MIN_WAIT = 2,
    parameter int TIMEOUT  = 64,
    parameter int MAX_OPR  = 10
) (
    input  wire logic         clock,
    input  wire logic         reset,
    cplx_alu_issue_if.slave   bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_WB    = 2'd3;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_rd;
    logic [63:0]   r_regs [NREGS];
    logic [63:0]   r_alu_a;
    logic [63:0]   r_alu_b;
    logic [4:0]    r_alu_opr;
    logic          r_alu_start;
    logic [63:0]   r_res_data;
    logic [AW-1:0] r_res_rd;
    logic          r_res_valid;
    logic          r_err_opr;
    logic          r_err_tout;

    logic w_opr_illegal;
    logic w_done_ok;

    assign w_opr_illegal = bus.cmd_opr > 5'(MAX_OPR);
    // The ALU result path is doubly registered, so early done pulses are stale.
    assign w_done_ok     = bus.alu_done && (r_cnt >= CW'(MIN_WAIT));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_rd        <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_opr   <= '0;
            r_alu_start <= 1'b0;
            r_res_data  <= '0;
            r_res_rd    <= '0;
            r_res_valid <= 1'b0;
            r_err_opr   <= 1'b0;
            r_err_tout  <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_res_valid <= 1'b0;
            r_err_opr   <= 1'b0;
            r_err_tout  <= 1'b0;

            if (bus.wr_en) begin
                r_regs[bus.wr_addr] <= bus.wr_data;
            end

            case (r_state)
                c_IDLE: begin
                    if (bus.cmd_valid) begin
                        if (w_opr_illegal) begin
                            r_err_opr <= 1'b1;
                        end else begin
                            r_alu_a   <= r_regs[bus.cmd_ra];
                            r_alu_b   <= r_regs[bus.cmd_rb];
                            r_alu_opr <= bus.cmd_opr;
                            r_rd      <= bus.cmd_rd;
                            r_state   <= c_ISSUE;
                        end
                    end
                end
                c_ISSUE: begin
                    r_alu_start <= 1'b1;
                    r_cnt       <= '0;
                    r_state     <= c_WAIT;
                end
                c_WAIT: begin
                    if (w_done_ok) begin
                        r_res_data <= bus.alu_outAB;
                        r_res_rd   <= r_rd;
                        r_state    <= c_WB;
                    end else if (r_cnt == CW'(TIMEOUT)) begin
                        r_err_tout  <= 1'b1;
                        r_alu_start <= 1'b0;
                        r_state     <= c_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_WB: begin
                    // Placed after the host write so writeback wins on a collision.
                    r_regs[r_rd] <= r_res_data;
                    r_res_valid  <= 1'b1;
                    r_alu_start  <= 1'b0;
                    r_state      <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = (r_state == c_IDLE) && !reset;
    assign bus.busy        = (r_state != c_IDLE);
    assign bus.rd_data     = r_regs[bus.rd_addr];
    assign bus.alu_inA     = r_alu_a;
    assign bus.alu_inB     = r_alu_b;
    assign bus.alu_opr     = r_alu_opr;
    assign bus.alu_start   = r_alu_start;
    assign bus.res_valid   = r_res_valid;
    assign bus.res_data    = r_res_data;
    assign bus.res_rd      = r_res_rd;
    assign bus.err_opr     = r_err_opr;
    assign bus.err_timeout = r_err_tout;

endmodule
`default_nettype wire
